tbus_pad_arbiter: RTL and testbench

- Arbitrates N requesters for one shared tristate net.
- The net is driven by per-requester TBUF_X1_LVT cells (active-high EN) and reaches the outside world through a PADBID cell (OEN active-low).
- Issues one-hot-or-zero grants with round-robin fairness, a bounded burst length, and mandatory all-off turnaround cycles between owners so no two drivers, or a driver and the pad, ever fight.
- Replaces the ad-hoc decoded enables currently feeding the TBUF/PADBID cells.

---
 rtl/tbus_pad_arbiter_if.sv | 24 ++
 rtl/tbus_pad_arbiter.sv | 151 +++++++++++++++
 tb/tb_tbus_pad_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tbus_pad_arbiter_if.sv
// Handshake bundle between the requesters and the tbus pad arbiter.
// master: requester side (req/wr out); slave: arbiter side (grants out).
interface tbus_pad_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   wr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   tbus_en;
  logic           pad_oen;
  logic           busy;
  logic [IDW-1:0] owner_id;

  modport master (
    output req, wr,
    input  gnt, tbus_en, pad_oen, busy, owner_id
  );

  modport slave (
    input  req, wr,
    output gnt, tbus_en, pad_oen, busy, owner_id
  );
endinterface

// File: rtl/tbus_pad_arbiter.sv
// Round-robin owner arbiter for a shared tristate net and its pad.
// Ports: CK, RN (async low), bus: req/wr in; gnt/tbus_en/pad_oen/busy/owner_id out.
module tbus_pad_arbiter #(
  parameter int N         = 4,
  parameter int TURN_CYC  = 1,
  parameter int MAX_BURST = 8,
  parameter int IDW       = $clog2(N)
) (
  input  logic                CK,
  input  logic                RN,
  tbus_pad_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_TURN
  } state_t;

  localparam logic [7:0]   LP_MAX  = 8'(MAX_BURST);
  localparam logic [2:0]   LP_TURN = 3'(TURN_CYC);
  localparam logic [N-1:0] LP_ONE  = N'(1);
  localparam logic [IDW-1:0] LP_LAST = IDW'(N - 1);

  state_t         r_state, w_state;
  logic [N-1:0]   r_gnt, w_gnt;
  logic           r_oen, w_oen;
  logic [IDW-1:0] r_owner, w_owner;
  logic [IDW-1:0] r_ptr, w_ptr;
  logic [7:0]     r_burst, w_burst;
  logic [2:0]     r_turn, w_turn;

  logic           w_any;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_nxt;
  logic           w_oth;
  logic           w_keep;

  // first set request at or above ptr, wrapping
  always_comb begin
    int j;
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(r_ptr) + i) % N;
      if (!w_any && bus.req[j]) begin
        w_any = 1'b1;
        w_win = IDW'(j);
      end
    end
  end

  assign w_keep = bus.req[r_owner];
  assign w_oth  = |(bus.req & ~(LP_ONE << r_owner));
  assign w_nxt  = (r_owner == LP_LAST) ? '0
                : r_owner + 1'b1;

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_oen   = r_oen;
    w_owner = r_owner;
    w_ptr   = r_ptr;
    w_burst = r_burst;
    w_turn  = r_turn;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state = S_OWN;
          w_gnt   = LP_ONE << w_win;
          w_owner = w_win;
          w_oen   = ~bus.wr[w_win];
          w_burst = 8'd1;
        end
      end
      S_OWN: begin
        // a non-owner X only reaches w_oth, which
        // cannot grant anyone by itself
        if (!w_keep || (r_burst == LP_MAX && w_oth)) begin
          w_state = S_TURN;
          w_gnt   = '0;
          w_oen   = 1'b1;
          w_ptr   = w_nxt;
          w_burst = '0;
          w_turn  = 3'd1;
        end else if (r_burst == LP_MAX) begin
          w_burst = 8'd1;
        end else begin
          w_burst = r_burst + 8'd1;
        end
      end
      S_TURN: begin
        if (r_turn == LP_TURN) begin
          w_turn = '0;
          if (w_any) begin
            w_state = S_OWN;
            w_gnt   = LP_ONE << w_win;
            w_owner = w_win;
            w_oen   = ~bus.wr[w_win];
            w_burst = 8'd1;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_turn = r_turn + 3'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_oen   <= 1'b1;
      r_owner <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_oen   <= w_oen;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_burst <= w_burst;
      r_turn  <= w_turn;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.tbus_en  = r_gnt;
  assign bus.pad_oen  = r_oen;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.owner_id = r_owner;

  a_onehot: assert property (
    @(posedge CK) disable iff (!RN)
    $onehot0(r_gnt));

  a_oen: assert property (
    @(posedge CK) disable iff (!RN)
    !r_oen |-> |r_gnt);

  a_nox: assert property (
    @(posedge CK) disable iff (!RN)
    !$isunknown({bus.req, bus.wr}));

endmodule

// File: tb/tb_tbus_pad_arbiter.sv
// Bench for tbus_pad_arbiter: vector table, directed corners, random vs model.
// Two DUTs (TURN_CYC 1 and 3) share stimulus, each with its own model.
module tb_tbus_pad_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] wr  = '0;

  always #5 CK = ~CK;

  tbus_pad_arbiter_if #(.N(N)) ifa ();
  tbus_pad_arbiter_if #(.N(N)) ifb ();

  assign ifa.req = req;
  assign ifa.wr  = wr;
  assign ifb.req = req;
  assign ifb.wr  = wr;

  tbus_pad_arbiter #(
    .N(N), .TURN_CYC(1), .MAX_BURST(MB)
  ) u_a (
    .CK(CK), .RN(RN), .bus(ifa)
  );

  tbus_pad_arbiter #(
    .N(N), .TURN_CYC(3), .MAX_BURST(MB)
  ) u_b (
    .CK(CK), .RN(RN), .bus(ifb)
  );

  logic [3:0] d_gnt [2];
  logic [3:0] d_ten [2];
  logic       d_oen [2];
  logic       d_busy[2];
  logic [1:0] d_id  [2];

  assign d_gnt[0]  = ifa.gnt;
  assign d_ten[0]  = ifa.tbus_en;
  assign d_oen[0]  = ifa.pad_oen;
  assign d_busy[0] = ifa.busy;
  assign d_id[0]   = ifa.owner_id;
  assign d_gnt[1]  = ifb.gnt;
  assign d_ten[1]  = ifb.tbus_en;
  assign d_oen[1]  = ifb.pad_oen;
  assign d_busy[1] = ifb.busy;
  assign d_id[1]   = ifb.owner_id;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // model: who owns the net, for how long, and how
  // many dead cycles are left before the next pick
  int m_tc   [2];
  bit m_own  [2];
  int m_id   [2];
  int m_burst[2];
  int m_gap  [2];
  int m_ptr  [2];
  bit m_oen  [2];

  function automatic void m_reset(int k);
    m_own[k]   = 0;
    m_id[k]    = 0;
    m_burst[k] = 0;
    m_gap[k]   = 0;
    m_ptr[k]   = 0;
    m_oen[k]   = 1;
  endfunction

  function automatic void m_pick(int k,
                                 logic [3:0] rq,
                                 logic [3:0] w);
    m_gap[k] = 0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr[k] + i) % N;
      if (rq[j] && !m_own[k]) begin
        m_own[k]   = 1;
        m_id[k]    = j;
        m_burst[k] = 1;
        m_oen[k]   = !w[j];
      end
    end
  endfunction

  function automatic void m_step(int k,
                                 logic [3:0] rq,
                                 logic [3:0] w);
    logic [3:0] oth;
    if (m_own[k]) begin
      oth = rq & ~(4'b0001 << m_id[k]);
      if (!rq[m_id[k]] ||
          (m_burst[k] == MB && oth != 0)) begin
        m_own[k] = 0;
        m_oen[k] = 1;
        m_gap[k] = m_tc[k];
        m_ptr[k] = (m_id[k] + 1) % N;
      end else begin
        m_burst[k] = (m_burst[k] == MB) ? 1
                   : m_burst[k] + 1;
      end
    end else if (m_gap[k] > 1) begin
      m_gap[k]--;
    end else begin
      m_pick(k, rq, w);
    end
  endfunction

  task automatic cyc();
    logic [3:0] eg;
    @(posedge CK);
    for (int k = 0; k < 2; k++) begin
      if (!RN) m_reset(k);
      else     m_step(k, req, wr);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      eg = m_own[k] ? (4'b0001 << m_id[k]) : 4'b0;
      chk($sformatf("gnt%0d", k), d_gnt[k], eg);
      chk($sformatf("tben%0d", k), d_ten[k], eg);
      chk($sformatf("oen%0d", k), d_oen[k],
          m_own[k] ? m_oen[k] : 1'b1);
      chk($sformatf("busy%0d", k), d_busy[k],
          (m_own[k] || m_gap[k] > 0));
      chk($sformatf("id%0d", k), d_id[k],
          m_id[k][1:0]);
      chk($sformatf("inv1hot%0d", k),
          ($countones(d_gnt[k]) <= 1), 1);
      chk($sformatf("invoen%0d", k),
          (!d_oen[k] && d_gnt[k] == 0), 0);
    end
  endtask

  task automatic rst();
    RN  = 1'b0;
    req = '0;
    wr  = '0;
    cyc();
    RN = 1'b1;
  endtask

  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic [3:0] wr;
    logic [3:0] gnt;
    logic       oen;
    logic       busy;
    logic [1:0] id;
  } vec_t;

  vec_t tv[$];

  int rr_own[5] = '{0, 1, 2, 3, 0};

  initial begin
    m_tc[0] = 1;
    m_tc[1] = 3;
    m_reset(0);
    m_reset(1);

    // reset, first grant, single long requester
    tv.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 1, 0, 0});
    tv.push_back(vec_t'{0, 4'hF, 4'h0, 4'h0, 1, 0, 0});
    tv.push_back(vec_t'{1, 4'h4, 4'h0, 4'h4, 1, 1, 2});
    tv.push_back(vec_t'{1, 4'h0, 4'h0, 4'h0, 1, 1, 2});
    tv.push_back(vec_t'{1, 4'h0, 4'h0, 4'h0, 1, 0, 2});
    tv.push_back(vec_t'{1, 4'h2, 4'h2, 4'h2, 0, 1, 1});
    for (int i = 0; i < 20; i++)
      tv.push_back(vec_t'{1, 4'h2,
                   (i < 10) ? 4'h2 : 4'h0,
                   4'h2, 0, 1, 1});
    tv.push_back(vec_t'{1, 4'h0, 4'h0, 4'h0, 1, 1, 1});
    tv.push_back(vec_t'{1, 4'h0, 4'h0, 4'h0, 1, 0, 1});

    foreach (tv[i]) begin
      RN  = tv[i].rn;
      req = tv[i].req;
      wr  = tv[i].wr;
      cyc();
      chk($sformatf("tv%0d_gnt", i), ifa.gnt, tv[i].gnt);
      chk($sformatf("tv%0d_oen", i), ifa.pad_oen, tv[i].oen);
      chk($sformatf("tv%0d_busy", i), ifa.busy, tv[i].busy);
      chk($sformatf("tv%0d_id", i), ifa.owner_id, tv[i].id);
    end

    // round robin, 8-cycle bursts, 1-cycle gaps
    rst();
    req = 4'hF;
    wr  = 4'h5;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < MB; c++) begin
        cyc();
        chk($sformatf("rr%0d_gnt", t), ifa.gnt,
            4'b0001 << rr_own[t]);
      end
      if (t < 4) begin
        cyc();
        chk($sformatf("rr%0d_gap", t), ifa.gnt, 0);
        chk($sformatf("rr%0d_gbusy", t), ifa.busy, 1);
      end
    end
    req = '0;
    repeat (4) cyc();

    // three-cycle turnaround on the TURN_CYC=3 unit
    rst();
    req = 4'b0001;
    wr  = 4'b0001;
    cyc();
    chk("ta_gnt0", ifb.gnt, 4'b0001);
    chk("ta_oen0", ifb.pad_oen, 0);
    req = 4'b1001;
    cyc();
    chk("ta_gnt1", ifb.gnt, 4'b0001);
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("ta_gap%0d", i), ifb.gnt, 0);
      chk($sformatf("ta_oen%0d", i), ifb.pad_oen, 1);
      chk($sformatf("ta_busy%0d", i), ifb.busy, 1);
    end
    cyc();
    chk("ta_new", ifb.gnt, 4'b1000);
    req = '0;
    repeat (5) cyc();

    // direction is latched at grant
    rst();
    req = 4'b0100;
    wr  = 4'b0000;
    cyc();
    chk("dl_gnt", ifa.gnt, 4'b0100);
    chk("dl_oen0", ifa.pad_oen, 1);
    wr = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("dl_hold%0d", i), ifa.pad_oen, 1);
    end
    req = '0;
    cyc();
    cyc();
    req = 4'b0100;
    cyc();
    chk("dl_gnt2", ifa.gnt, 4'b0100);
    chk("dl_oen2", ifa.pad_oen, 0);

    // async reset pulse mid-tenure
    rst();
    req = 4'b1000;
    wr  = 4'b1000;
    cyc();
    chk("ar_gnt", ifa.gnt, 4'b1000);
    chk("ar_oen", ifa.pad_oen, 0);
    cyc();
    #2 RN = 1'b0;
    #1;
    chk("ar_rgnt", ifa.gnt, 0);
    chk("ar_rten", ifa.tbus_en, 0);
    chk("ar_roen", ifa.pad_oen, 1);
    chk("ar_rbusy", ifa.busy, 0);
    m_reset(0);
    m_reset(1);
    #1 RN = 1'b1;
    req = 4'b1010;
    wr  = 4'b0000;
    cyc();
    chk("ar_first", ifa.gnt, 4'b0010);
    chk("ar_id", ifa.owner_id, 1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      req = r;
      wr  = 4'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
